// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
//   state_t          : arbiter FSM states
//   UART_FRAME_BITS  : start + 8 data + stop
//   DEFAULT_CLKS_PB  : default clocks per bit
package uart_pkg;

  typedef enum logic [1:0] {
    GUARD = 2'd0,
    IDLE  = 2'd1,
    START = 2'd2,
    BUSY  = 2'd3
  } state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int DEFAULT_CLKS_PB = 217;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Scans i_Last+1, i_Last+2, ... (mod p_NUM_REQ) and returns the first set
// request. When i_Lock is set, only i_Last is a candidate.
//   i_Req   : request vector
//   i_Last  : index granted last time
//   i_Lock  : restrict the candidate set to i_Last
//   o_Found : some candidate is requesting
//   o_Idx   : chosen index (i_Last when nothing is found)
module rr_picker #(
  parameter int p_NUM_REQ = 4,
  parameter int p_IDX_W   = $clog2(p_NUM_REQ)
) (
  input  logic [p_NUM_REQ-1:0] i_Req,
  input  logic [p_IDX_W-1:0]   i_Last,
  input  logic                 i_Lock,
  output logic                 o_Found,
  output logic [p_IDX_W-1:0]   o_Idx
);

  logic [p_IDX_W-1:0] w_Idx;

  always_comb begin
    o_Found = 1'b0;
    o_Idx   = i_Last;
    w_Idx   = '0;
    if (i_Lock) begin
      o_Found = i_Req[i_Last];
    end else begin
      // Walk offsets from farthest to nearest so the nearest hit is the
      // last assignment and wins; offset p_NUM_REQ is i_Last itself.
      for (int k = p_NUM_REQ; k >= 1; k--) begin
        w_Idx = p_IDX_W'((int'(i_Last) + k) % p_NUM_REQ);
        if (i_Req[w_Idx]) begin
          o_Found = 1'b1;
          o_Idx   = w_Idx;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX between p_NUM_REQ byte sources, round-robin, with an
// optional per-requester lock so multi-byte messages stay contiguous.
// One start pulse per byte; waits for the completion pulse before the next
// grant. After reset a guard period of one frame lets a UART_TX (which has no
// reset) finish any frame it was sending.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN (adds o_Timeout and a BUSY
// watchdog of p_TIMEOUT_CLKs cycles).
//   i_Clk, i_Rst_L   : clock, async active-low reset
//   i_Req_Valid/Byte/Lock : per-requester byte interface
//   o_Req_Ack        : one-cycle consume pulse per requester
//   o_Tx_Byte, o_Tx_Start, i_Tx_Completed : UART_TX interface
//   o_Grant_Idx      : current/last granted requester
//   o_Busy           : high in every state except IDLE
//   o_Timeout        : (optional) BUSY watchdog expired
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int p_NUM_REQ      = 4,
  parameter int p_CLKs_PB      = DEFAULT_CLKS_PB,
  parameter int p_TIMEOUT_CLKs = 12 * p_CLKs_PB
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic [p_NUM_REQ-1:0]         i_Req_Valid,
  input  logic [8*p_NUM_REQ-1:0]       i_Req_Byte,
  input  logic [p_NUM_REQ-1:0]         i_Req_Lock,
  output logic [p_NUM_REQ-1:0]         o_Req_Ack,
  output logic [7:0]                   o_Tx_Byte,
  output logic                         o_Tx_Start,
  input  logic                         i_Tx_Completed,
  output logic [$clog2(p_NUM_REQ)-1:0] o_Grant_Idx,
  output logic                         o_Busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                         o_Timeout
`endif
);

  localparam int IW         = $clog2(p_NUM_REQ);
  localparam int GUARD_CLKS = UART_FRAME_BITS * p_CLKs_PB;
  localparam int GW         = $clog2(GUARD_CLKS);

  state_t               r_State,     w_State_Nxt;
  logic [GW-1:0]        r_Guard_Cnt, w_Guard_Cnt_Nxt;
  logic [p_NUM_REQ-1:0] r_Ack,       w_Ack_Nxt;
  logic                 r_Tx_Start,  w_Tx_Start_Nxt;
  logic [7:0]           r_Tx_Byte,   w_Tx_Byte_Nxt;
  logic [IW-1:0]        r_Grant_Idx, w_Grant_Nxt;
  logic                 r_Lock,      w_Lock_Nxt;

  logic                 w_Found;
  logic [IW-1:0]        w_Pick;
  logic [7:0]           w_Pick_Byte;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(p_TIMEOUT_CLKs);
  logic [TW-1:0]        r_To_Cnt,    w_To_Cnt_Nxt;
  logic                 r_Timeout,   w_Timeout_Nxt;
`endif

  rr_picker #(.p_NUM_REQ(p_NUM_REQ), .p_IDX_W(IW)) u_rr_picker (
    .i_Req   (i_Req_Valid),
    .i_Last  (r_Grant_Idx),
    .i_Lock  (r_Lock),
    .o_Found (w_Found),
    .o_Idx   (w_Pick)
  );

  assign w_Pick_Byte = i_Req_Byte[{w_Pick, 3'b000} +: 8];

  always_comb begin
    w_State_Nxt     = r_State;
    w_Guard_Cnt_Nxt = r_Guard_Cnt;
    w_Ack_Nxt       = '0;
    w_Tx_Start_Nxt  = 1'b0;
    w_Tx_Byte_Nxt   = r_Tx_Byte;
    w_Grant_Nxt     = r_Grant_Idx;
    w_Lock_Nxt      = r_Lock;
`ifdef UART_TX_ARB_TIMEOUT_EN
    w_To_Cnt_Nxt    = r_To_Cnt;
    w_Timeout_Nxt   = 1'b0;
`endif
    case (r_State)
      GUARD: begin
        // i_Tx_Completed is deliberately ignored: it may belong to a frame
        // started before reset.
        if (r_Guard_Cnt == GW'(GUARD_CLKS - 1)) begin
          w_State_Nxt     = IDLE;
          w_Guard_Cnt_Nxt = '0;
        end else begin
          w_Guard_Cnt_Nxt = r_Guard_Cnt + 1'b1;
        end
      end
      IDLE: begin
        // A locked requester that walks away releases the lock; normal
        // arbitration resumes on the following cycle.
        if (r_Lock && !i_Req_Valid[r_Grant_Idx]) begin
          w_Lock_Nxt = 1'b0;
        end else if (w_Found) begin
          w_Grant_Nxt       = w_Pick;
          w_Tx_Byte_Nxt     = w_Pick_Byte;
          w_Lock_Nxt        = i_Req_Lock[w_Pick];
          w_Ack_Nxt[w_Pick] = 1'b1;
          w_State_Nxt       = START;
        end
      end
      START: begin
        w_Tx_Start_Nxt = 1'b1;
        w_State_Nxt    = BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_To_Cnt_Nxt   = '0;
`endif
      end
      BUSY: begin
        if (i_Tx_Completed) begin
          w_State_Nxt = IDLE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (r_To_Cnt == TW'(p_TIMEOUT_CLKs - 1)) begin
          w_Timeout_Nxt = 1'b1;
          w_Lock_Nxt    = 1'b0;
          w_State_Nxt   = IDLE;
        end else begin
          w_To_Cnt_Nxt = r_To_Cnt + 1'b1;
        end
`endif
      end
      default: w_State_Nxt = GUARD;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= GUARD;
      r_Guard_Cnt <= '0;
      r_Ack       <= '0;
      r_Tx_Start  <= 1'b0;
      r_Tx_Byte   <= '0;
      r_Grant_Idx <= IW'(p_NUM_REQ - 1);
      r_Lock      <= 1'b0;
    end else begin
      r_State     <= w_State_Nxt;
      r_Guard_Cnt <= w_Guard_Cnt_Nxt;
      r_Ack       <= w_Ack_Nxt;
      r_Tx_Start  <= w_Tx_Start_Nxt;
      r_Tx_Byte   <= w_Tx_Byte_Nxt;
      r_Grant_Idx <= w_Grant_Nxt;
      r_Lock      <= w_Lock_Nxt;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_To_Cnt  <= '0;
      r_Timeout <= 1'b0;
    end else begin
      r_To_Cnt  <= w_To_Cnt_Nxt;
      r_Timeout <= w_Timeout_Nxt;
    end
  end
  assign o_Timeout = r_Timeout;
`endif

  assign o_Req_Ack   = r_Ack;
  assign o_Tx_Byte   = r_Tx_Byte;
  assign o_Tx_Start  = r_Tx_Start;
  assign o_Grant_Idx = r_Grant_Idx;
  assign o_Busy      = (r_State != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX instance between p_NUM_REQ byte sources, e.g. the RX echo path, a hex-dump formatter and a status reporter.
- Arbitrates round-robin, with optional per-requester lock so multi-byte messages are not interleaved.
- Sequences UART_TX: one start pulse per byte, then waits for the completion pulse before the next grant.
- Sits between the byte producers and UART_TX in the top-level.

Parameters:
- p_NUM_REQ, 4, number of requesters (2..8).
- p_CLKs_PB, 217, clocks per bit; must match the UART_TX instance.
- p_TIMEOUT_CLKs, 12*p_CLKs_PB, BUSY watchdog limit (used only with the optional feature).

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Req_Valid  in  p_NUM_REQ  requester n has a byte pending
- i_Req_Byte  in  8*p_NUM_REQ  byte n at [8n+7:8n]
- i_Req_Lock  in  p_NUM_REQ  keep the grant after this byte (more message bytes follow)
- o_Req_Ack  out  p_NUM_REQ  one-cycle pulse: byte n consumed
- o_Tx_Byte  out  8  to UART_TX i_Tx_Byte
- o_Tx_Start  out  1  to UART_TX i_Tx_Ready; one-cycle start pulse
- i_Tx_Completed  in  1  from UART_TX o_Tx_Completed; one-cycle pulse at end of stop bit
- o_Grant_Idx  out  $clog2(p_NUM_REQ)  current or last granted requester
- o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, i_Rst_L=0):
  - State GUARD; guard counter = 0.
  - o_Req_Ack=0, o_Tx_Start=0, o_Tx_Byte=0, o_Grant_Idx=p_NUM_REQ-1, lock flag=0, o_Busy=1.
- GUARD: UART_TX has no reset and may still be mid-frame. Count 10*p_CLKs_PB cycles, then go to IDLE. i_Tx_Completed is ignored here.
- IDLE:
  - Candidate set = all i_Req_Valid when the lock flag is 0; only i_Req_Valid[o_Grant_Idx] when the lock flag is 1.
  - If the candidate set is empty, stay in IDLE.
  - Otherwise pick the first valid index scanning o_Grant_Idx+1, +2, … modulo p_NUM_REQ. A locked requester is its own sole candidate.
  - On the selecting edge, all registered together: o_Grant_Idx=g, o_Tx_Byte=byte g, lock flag=i_Req_Lock[g], o_Req_Ack[g]=1 for exactly one cycle; state to START.
- START: o_Tx_Start=1 for exactly one cycle; state to BUSY.
- BUSY:
  - Hold o_Tx_Byte stable.
  - On i_Tx_Completed=1, go to IDLE.
- Latency: valid sampled at edge k -> ack high k..k+1 -> o_Tx_Start high k+1..k+2. Back-to-back bytes lose 2 cycles after completion.
- Requester rules:
  - Hold valid and byte stable until ack.
  - The value seen in the cycle after ack is treated as the next byte.
  - Dropping valid before ack is allowed; that request is simply not granted.
- Lock boundaries:
  - If the lock flag is 1 and the locked requester drops valid in IDLE, clear the lock flag the same cycle and arbitrate normally in the next cycle.
  - Lock on the final byte: requester clears i_Req_Lock with the last byte.
- i_Tx_Completed outside BUSY is ignored.
- Simultaneous new valid and completion: the new valid is considered in IDLE one cycle later.
- Reset mid-frame: the FSM is forced to GUARD. The pending ack is lost, and the requester re-presents the byte.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - Adds port o_Timeout (out, 1) and a BUSY cycle counter.
  - If the counter reaches p_TIMEOUT_CLKs without i_Tx_Completed: o_Timeout pulses one cycle, the lock flag clears, state goes to IDLE.
  - The counter clears on entry to BUSY.
- Undefined: no port and no counter; BUSY waits indefinitely.

Decomposition:
- Package uart_pkg:
  - state enum {GUARD, IDLE, START, BUSY}
  - UART_FRAME_BITS=10
  - default clocks-per-bit constant 217
- Sub-module rr_picker: combinational; inputs request vector, last index, lock flag; outputs grant-found and index. Reusable by later arbiters.

Test Plan (p_CLKs_PB=4, p_NUM_REQ=4, UART_TX model replies 40 cycles after start):
- Reset, then req0 valid 0x41 immediately -> no ack for 40 cycles (GUARD); then ack0 pulse, o_Tx_Start one cycle later with o_Tx_Byte=0x41.
- Req1=0x31, req2=0x32, req3=0x33 all held valid -> grant order 1,2,3; exactly one o_Tx_Start per i_Tx_Completed.
- Req0 locked for bytes 0x0D,0x0A with req1 valid -> both req0 bytes sent before any req1 grant; then req1.
- Locked req2 drops valid in IDLE -> lock clears; req3 (valid) granted next cycle.
- Assert i_Rst_L=0 during BUSY -> all outputs at reset values asynchronously; GUARD re-entered; i_Tx_Completed during GUARD ignored.
- With UART_TX_ARB_TIMEOUT_EN and the model never completing -> o_Timeout pulse 48 cycles after BUSY entry; FSM back in IDLE and grants the next requester.
